// File: rtl/decode_stage.sv
// RV32I decode stage: captures one instruction, decodes fields/immediate, holds it against a
// pending-write scoreboard, reads operands from register_file and hands a bundle to execute.
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic [4:0]  reg_num_1,
    output logic [4:0]  reg_num_2,
    input  logic [31:0] reg_1,
    input  logic [31:0] reg_2,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_funct3,
    output logic        out_funct7b5,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic [31:0] out_imm,
    output logic [31:0] out_op1,
    output logic [31:0] out_op2,
    output logic        out_illegal
);

    typedef enum logic [1:0] {StIdle, StCheck, StRead, StValid} state_e;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpOp     = 7'b0110011;

    state_e      state_q, state_d;
    logic [31:0] pc_q, imm_q, op1_q, op2_q;
    logic [31:0] busy_q, busy_d;
    logic [6:0]  opcode_q;
    logic [4:0]  rd_q, rs1_q, rs2_q;
    logic [2:0]  funct3_q;
    logic        funct7b5_q, we_q, illegal_q, use1_q, use2_q;

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] dec_imm;
    logic        dec_we, dec_illegal, dec_use1, dec_use2;
    logic        capture, sample, handshake, hazard;

    assign imm_i = {{21{in_instr[31]}}, in_instr[30:20]};
    assign imm_s = {{21{in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
    assign imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    always_comb begin
        dec_imm     = '0;
        dec_we      = 1'b0;
        dec_illegal = 1'b0;
        dec_use1    = 1'b0;
        dec_use2    = 1'b0;
        case (in_instr[6:0])
            OpLui, OpAuipc: begin
                dec_imm = imm_u;
                dec_we  = 1'b1;
            end
            OpJal: begin
                dec_imm = imm_j;
                dec_we  = 1'b1;
            end
            OpJalr, OpLoad, OpImm: begin
                dec_imm  = imm_i;
                dec_we   = 1'b1;
                dec_use1 = 1'b1;
            end
            OpBranch: begin
                dec_imm  = imm_b;
                dec_use1 = 1'b1;
                dec_use2 = 1'b1;
            end
            OpStore: begin
                dec_imm  = imm_s;
                dec_use1 = 1'b1;
                dec_use2 = 1'b1;
            end
            OpOp: begin
                dec_we   = 1'b1;
                dec_use1 = 1'b1;
                dec_use2 = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
        if (in_instr[11:7] == 5'd0) begin
            dec_we = 1'b0;
        end
    end

    // Registered busy only: a writeback clear is seen by CHECK one cycle later.
    assign hazard    = (use1_q && busy_q[rs1_q]) || (use2_q && busy_q[rs2_q]);
    assign handshake = (state_q == StValid) && out_ready && !flush;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        sample  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid && !flush) begin
                    state_d = StCheck;
                    capture = 1'b1;
                end
            end
            StCheck: begin
                if (!hazard) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                state_d = StValid;
                sample  = 1'b1;
            end
            StValid: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
        end
    end

    // Set wins over a same-cycle writeback clear; flush never touches busy.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (handshake && we_q) begin
            busy_d[rd_q] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= '0;
            imm_q      <= '0;
            opcode_q   <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
            we_q       <= 1'b0;
            illegal_q  <= 1'b0;
            use1_q     <= 1'b0;
            use2_q     <= 1'b0;
        end else if (capture) begin
            pc_q       <= in_pc;
            imm_q      <= dec_imm;
            opcode_q   <= in_instr[6:0];
            rd_q       <= in_instr[11:7];
            rs1_q      <= in_instr[19:15];
            rs2_q      <= in_instr[24:20];
            funct3_q   <= in_instr[14:12];
            funct7b5_q <= in_instr[30];
            we_q       <= dec_we;
            illegal_q  <= dec_illegal;
            use1_q     <= dec_use1;
            use2_q     <= dec_use2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op1_q <= '0;
            op2_q <= '0;
        end else if (sample) begin
            op1_q <= (rs1_q == 5'd0) ? 32'd0 : reg_1;
            op2_q <= (rs2_q == 5'd0) ? 32'd0 : reg_2;
        end
    end

    assign in_ready     = (state_q == StIdle) && !flush;
    assign out_valid    = (state_q == StValid);
    assign reg_num_1    = rs1_q;
    assign reg_num_2    = rs2_q;
    assign out_pc       = pc_q;
    assign out_opcode   = opcode_q;
    assign out_funct3   = funct3_q;
    assign out_funct7b5 = funct7b5_q;
    assign out_rd       = rd_q;
    assign out_we       = we_q;
    assign out_imm      = imm_q;
    assign out_op1      = op1_q;
    assign out_op2      = op2_q;
    assign out_illegal  = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a transaction-level model of the stage and its scoreboard.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush;
    logic [31:0] in_instr, in_pc;
    logic [4:0]  reg_num_1, reg_num_2;
    logic [31:0] reg_1, reg_2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_imm, out_op1, out_op2;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic        out_funct7b5, out_we, out_illegal;
    logic [4:0]  out_rd;

    decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .flush(flush), .reg_num_1(reg_num_1), .reg_num_2(reg_num_2),
        .reg_1(reg_1), .reg_2(reg_2), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode),
        .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_rd(out_rd), .out_we(out_we),
        .out_imm(out_imm), .out_op1(out_op1), .out_op2(out_op2), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // register_file stand-in: data follows the index by one cycle
    logic [31:0] regs [32];
    always @(posedge clk) begin
        reg_1 <= regs[reg_num_1];
        reg_2 <= regs[reg_num_2];
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference decode straight from the ISA field layout
    function automatic void ref_decode(input logic [31:0] ins, output logic [31:0] imm,
                                       output bit we, output bit ill, output bit u1,
                                       output bit u2);
        logic [31:0] sx;
        sx  = ins[31] ? 32'hFFFF_FFFF : 32'h0;
        imm = 32'h0; we = 0; ill = 0; u1 = 0; u2 = 0;
        case (ins[6:0])
            7'b0110111, 7'b0010111: begin imm = ins & 32'hFFFF_F000; we = 1; end
            7'b1101111: begin
                imm = (sx << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11)
                    | (32'(ins[30:21]) << 1);
                we = 1;
            end
            7'b1100111, 7'b0000011, 7'b0010011: begin
                imm = (sx << 11) | 32'(ins[30:20]); we = 1; u1 = 1;
            end
            7'b1100011: begin
                imm = (sx << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5)
                    | (32'(ins[11:8]) << 1);
                u1 = 1; u2 = 1;
            end
            7'b0100011: begin
                imm = (sx << 11) | (32'(ins[30:25]) << 5) | 32'(ins[11:7]); u1 = 1; u2 = 1;
            end
            7'b0110011: begin we = 1; u1 = 1; u2 = 1; end
            default: ill = 1;
        endcase
        if (ins[11:7] == 5'd0) we = 0;
    endfunction

    // Model: m_held = an instruction is in the stage; m_left = cycles until its bundle shows
    bit          m_held, m_we, m_ill, m_u1, m_u2;
    int          m_left;
    logic [31:0] m_instr, m_pc, m_imm, m_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_held = 0; m_left = 0; m_instr = 0; m_pc = 0; m_imm = 0;
            m_we = 0; m_ill = 0; m_u1 = 0; m_u2 = 0; m_busy = 0;
        end else begin
            bit hs, hz;
            logic [31:0] nb;
            hs = m_held && (m_left == 0) && out_ready && !flush;
            hz = (m_u1 && m_busy[m_instr[19:15]]) || (m_u2 && m_busy[m_instr[24:20]]);
            nb = m_busy;
            if (wb_valid) nb[wb_rd] = 1'b0;
            if (hs && m_we) nb[m_instr[11:7]] = 1'b1;
            nb[0] = 1'b0;
            m_busy = nb;
            if (flush) m_held = 0;
            else if (!m_held) begin
                if (in_valid) begin
                    m_held = 1; m_left = 2; m_instr = in_instr; m_pc = in_pc;
                    ref_decode(in_instr, m_imm, m_we, m_ill, m_u1, m_u2);
                end
            end else if (m_left == 2) begin
                if (!hz) m_left = 1;
            end else if (m_left == 1) m_left = 0;
            else if (out_ready) m_held = 0;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, !m_held && !flush);
        chk("out_valid", out_valid, m_held && (m_left == 0));
        chk("reg_num_1", reg_num_1, m_instr[19:15]);
        chk("reg_num_2", reg_num_2, m_instr[24:20]);
        chk("out_pc", out_pc, m_pc);
        chk("out_opcode", out_opcode, m_instr[6:0]);
        chk("out_funct3", out_funct3, m_instr[14:12]);
        chk("out_funct7b5", out_funct7b5, m_instr[30]);
        chk("out_rd", out_rd, m_instr[11:7]);
        chk("out_we", out_we, m_we);
        chk("out_imm", out_imm, m_imm);
        chk("out_illegal", out_illegal, m_ill);
        chk("busy", dut.busy_q, m_busy);
        if (m_held && m_left == 0) begin
            chk("out_op1", out_op1, (m_instr[19:15] == 0) ? 32'h0 : regs[m_instr[19:15]]);
            chk("out_op2", out_op2, (m_instr[24:20] == 0) ? 32'h0 : regs[m_instr[24:20]]);
        end
    end

    logic [31:0] pc_ctr = 32'h1000;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins);
        in_valid = 1; in_instr = ins; in_pc = pc_ctr; pc_ctr += 4;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                cyc();
                break;
            end
            cyc();
        end
        in_valid = 0;
    endtask

    // Returns how many negedges after the call out_valid first shows (0 = never)
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic handshake();
        out_ready = 1;
        cyc();
        out_ready = 0;
    endtask

    task automatic retire(input logic [4:0] r);
        wb_valid = 1; wb_rd = r;
        cyc();
        wb_valid = 0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 9))
            0: w[6:0] = 7'b0110111;
            1: w[6:0] = 7'b0010111;
            2: w[6:0] = 7'b1101111;
            3: w[6:0] = 7'b1100111;
            4: w[6:0] = 7'b1100011;
            5: w[6:0] = 7'b0000011;
            6: w[6:0] = 7'b0100011;
            7: w[6:0] = 7'b0010011;
            8: w[6:0] = 7'b0110011;
            default: ;
        endcase
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    initial begin
        int lat;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        in_valid = 0; in_instr = 0; in_pc = 0; flush = 0;
        wb_valid = 0; wb_rd = 0; out_ready = 0;
        rst = 0;
        #1 rst = 1;
        cyc(); cyc();
        rst = 0;

        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_imm", out_imm, 0);
        chk("rst busy", dut.busy_q, 0);

        // addi x1,x0,5
        issue(32'h0050_0093);
        wait_valid(lat);
        chk("addi latency", lat, 3);
        chk("addi rd", out_rd, 1);
        chk("addi imm", out_imm, 5);
        chk("addi we", out_we, 1);
        chk("addi op1", out_op1, 0);
        chk("addi illegal", out_illegal, 0);
        handshake();
        chk("addi busy", dut.busy_q, 32'h2);

        // add x3,x1,x2 stalls on x1; the clear lands at the edge closing the wb cycle
        issue(32'h0020_81B3);
        cyc(); cyc(); cyc(); cyc();
        chk("add stalled", out_valid, 0);
        retire(5'd1);
        wait_valid(lat);
        chk("add release latency", lat, 3);
        chk("add op1", out_op1, 5);
        chk("add op2", out_op2, 7);
        chk("add rd", out_rd, 3);
        handshake();
        chk("add busy", dut.busy_q, 32'h8);
        retire(5'd3);

        // beq x1,x2,-4
        issue(32'hFE20_8EE3);
        wait_valid(lat);
        chk("beq imm", out_imm, 32'hFFFF_FFFC);
        chk("beq we", out_we, 0);
        handshake();
        chk("beq busy", dut.busy_q, 0);

        // lui x5 with its rs1 field (x8) busy: no stall
        issue(32'h0050_0413);
        wait_valid(lat);
        handshake();
        issue(32'h1234_52B7);
        wait_valid(lat);
        chk("lui latency", lat, 3);
        chk("lui imm", out_imm, 32'h1234_5000);
        handshake();
        chk("lui busy", dut.busy_q, 32'h120);
        retire(5'd8);
        retire(5'd5);

        issue(32'h0000_007F);
        wait_valid(lat);
        chk("illegal flag", out_illegal, 1);
        chk("illegal we", out_we, 0);
        chk("illegal imm", out_imm, 0);
        handshake();
        issue(32'h0050_0013);
        wait_valid(lat);
        chk("x0 dest we", out_we, 0);
        handshake();
        chk("x0 dest busy", dut.busy_q, 0);

        // flush in CHECK, READ, VALID (+out_ready)
        for (int s = 0; s < 3; s++) begin
            issue(32'h0050_0093);
            for (int k = 0; k < s; k++) cyc();
            flush = 1;
            out_ready = (s == 2);
            cyc();
            flush = 0;
            out_ready = 0;
            @(negedge clk);
            chk("flush out_valid", out_valid, 0);
            chk("flush in_ready", in_ready, 1);
            chk("flush busy", dut.busy_q, 0);
            cyc();
        end

        // flush blocks a coincident accept
        in_valid = 1; in_instr = 32'h0050_0093; flush = 1;
        #1 chk("flush in_ready low", in_ready, 0);
        cyc();
        in_valid = 0; flush = 0;
        cyc(); cyc(); cyc(); cyc();
        chk("flush no accept", out_valid, 0);

        // addi x4 handshake with a same-cycle retire of x4: set wins
        issue(32'h0010_0213);
        wait_valid(lat);
        out_ready = 1; wb_valid = 1; wb_rd = 5'd4;
        cyc();
        out_ready = 0; wb_valid = 0;
        chk("set wins busy", dut.busy_q, 32'h10);

        // add x5,x4,x0 stalls; reset mid-stall
        issue(32'h0002_02B3);
        cyc(); cyc(); cyc();
        chk("x4 stall", out_valid, 0);
        rst = 1;
        #1;
        chk("mid rst in_ready", in_ready, 1);
        chk("mid rst out_valid", out_valid, 0);
        chk("mid rst out_rd", out_rd, 0);
        chk("mid rst out_pc", out_pc, 0);
        chk("mid rst out_imm", out_imm, 0);
        chk("mid rst reg_num_1", reg_num_1, 0);
        chk("mid rst busy", dut.busy_q, 0);
        cyc();
        rst = 0;
        cyc();

        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 39) == 0);
            wb_valid  = 0;
            if ((m_busy & ~32'h1) != 0 && $urandom_range(0, 2) == 0) begin
                int off;
                off = $urandom_range(0, 30);
                for (int k = 0; k < 31; k++) begin
                    int j;
                    j = 1 + ((off + k) % 31);
                    if (m_busy[j]) begin
                        wb_valid = 1;
                        wb_rd = 5'(j);
                        break;
                    end
                end
            end else if ($urandom_range(0, 19) == 0) begin
                wb_valid = 1;
                wb_rd = 5'($urandom_range(0, 31));
            end
            if (!m_held && !in_valid && $urandom_range(0, 9) == 0)
                regs[$urandom_range(1, 31)] = $urandom;
            cyc();
        end
        in_valid = 0; out_ready = 0; flush = 0; wb_valid = 0;
        cyc(); cyc();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
